// File: rtl/snn_inference_ctrl.sv
// Inference sequencer: streams the stored image into the SNN core, starts it, and holds the digit for the AXI side.
// Optional RUN watchdog is compiled in when SNN_INFER_TIMEOUT_EN is defined.
module snn_inference_ctrl #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = 8,
  parameter int PIXEL_BITS      = 8,
  parameter int DIGIT_BITS      = 8,
  parameter int CYCLE_CNT_BITS  = 24
`ifdef SNN_INFER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  NEW_IMAGE,
  input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
  output logic [PIXEL_BITS-1:0]                 PIX_DATA,
  output logic [IMAGE_SIZE_BITS-1:0]            PIX_ADDR,
  output logic                                  PIX_VALID,
  input  logic                                  PIX_READY,
  output logic                                  SNN_START,
  input  logic                                  SNN_DONE,
  input  logic [DIGIT_BITS-1:0]                 SNN_DIGIT,
  output logic [DIGIT_BITS-1:0]                 INFERED_DIGIT,
  output logic                                  COPROCESSOR_RDY,
  input  logic                                  RESULT_ACK,
  output logic                                  BUSY,
  output logic                                  OVERRUN,
  output logic [CYCLE_CNT_BITS-1:0]             INFER_CYCLES,
  output logic                                  TIMEOUT_ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_RESULT} state_e;

  localparam logic [IMAGE_SIZE_BITS-1:0] LAST_ADDR = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);

  state_e                     state_q, state_d;
  logic                       new_q;
  logic                       new_edge;
  logic [IMAGE_SIZE_BITS-1:0] addr_q, addr_d;
  logic                       start_q, start_d;
  logic [DIGIT_BITS-1:0]      digit_q, digit_d;
  logic                       rdy_q, rdy_d;
  logic                       busy_q;
  logic                       overrun_q, overrun_d;
  logic [CYCLE_CNT_BITS-1:0]  cycles_q, cycles_d;
  logic                       load_enter;
  logic                       run_enter;
  logic                       wd_expired;

  assign new_edge = NEW_IMAGE & ~new_q;

`ifdef SNN_INFER_TIMEOUT_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_BITS-1:0] wd_q, wd_d;
  logic               tmo_q, tmo_d;

  assign wd_expired  = (wd_q == WD_BITS'(TIMEOUT_CYCLES));
  assign TIMEOUT_ERR = tmo_q;

  // The watchdog reads 1 on the start cycle, so expiry lands on the TIMEOUT_CYCLES-th RUN cycle.
  always_comb begin
    wd_d  = wd_q;
    tmo_d = tmo_q;
    if (run_enter)              wd_d = WD_BITS'(1);
    else if (state_q == ST_RUN) wd_d = wd_q + 1'b1;
    if (load_enter)                                       tmo_d = 1'b0;
    else if (state_q == ST_RUN && !SNN_DONE && wd_expired) tmo_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end
`else
  assign wd_expired  = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    start_d    = 1'b0;
    digit_d    = digit_q;
    rdy_d      = rdy_q;
    overrun_d  = overrun_q;
    cycles_d   = cycles_q;
    load_enter = 1'b0;
    run_enter  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (new_edge) begin
          state_d    = ST_LOAD;
          load_enter = 1'b1;
        end
      end
      ST_LOAD: begin
        if (new_edge) overrun_d = 1'b1;
        if (PIX_READY) begin
          if (addr_q == LAST_ADDR) begin
            state_d   = ST_RUN;
            start_d   = 1'b1;
            run_enter = 1'b1;
            addr_d    = '0;
            cycles_d  = CYCLE_CNT_BITS'(1);
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (new_edge) overrun_d = 1'b1;
        if (SNN_DONE) begin
          digit_d = SNN_DIGIT;
          rdy_d   = 1'b1;
          state_d = ST_RESULT;
        end else if (wd_expired) begin
          digit_d = '1;
          rdy_d   = 1'b1;
          state_d = ST_RESULT;
        end else if (cycles_q != '1) begin
          cycles_d = cycles_q + 1'b1;
        end
      end
      ST_RESULT: begin
        if (new_edge) begin
          // A new image pre-empts an unread result; only a same-cycle ACK makes that legitimate.
          rdy_d      = 1'b0;
          state_d    = ST_LOAD;
          load_enter = 1'b1;
          if (!RESULT_ACK) overrun_d = 1'b1;
        end else if (RESULT_ACK) begin
          rdy_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_enter) begin
      addr_d   = '0;
      cycles_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments; reset is synchronous, so it sits inside the clocked branch.
    if (RST) begin
      state_q   <= ST_IDLE;
      new_q     <= 1'b0;
      addr_q    <= '0;
      start_q   <= 1'b0;
      digit_q   <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      new_q     <= NEW_IMAGE;
      addr_q    <= addr_d;
      start_q   <= start_d;
      digit_q   <= digit_d;
      rdy_q     <= rdy_d;
      busy_q    <= (state_d == ST_LOAD) || (state_d == ST_RUN);
      overrun_q <= overrun_d;
      cycles_q  <= cycles_d;
    end
  end

  assign PIX_VALID       = (state_q == ST_LOAD);
  assign PIX_ADDR        = addr_q;
  assign PIX_DATA        = PIX_VALID ? IMAGE[addr_q] : '0;
  assign SNN_START       = start_q;
  assign INFERED_DIGIT   = digit_q;
  assign COPROCESSOR_RDY = rdy_q;
  assign BUSY            = busy_q;
  assign OVERRUN         = overrun_q;
  assign INFER_CYCLES    = cycles_q;

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Scoreboard bench for snn_inference_ctrl: expected pixel beats and results are queued by the driver,
// and an independent monitor pops and compares them as the DUT presents them.
module tb_snn_inference_ctrl;

  localparam int N   = 256;
  localparam int TMO = 50;
`ifdef SNN_INFER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct { logic [7:0] addr; logic [7:0] data; } beat_t;
  typedef struct { logic [7:0] digit; int cycles; logic tmo; } res_t;

  beat_t pix_q[$];
  res_t  res_q[$];

  logic               CLK = 1'b0;
  logic               RST, NEW_IMAGE, PIX_READY, SNN_DONE, RESULT_ACK;
  logic [N-1:0][7:0]  IMAGE;
  logic [7:0]         SNN_DIGIT;
  logic [7:0]         PIX_DATA, PIX_ADDR, INFERED_DIGIT;
  logic               PIX_VALID, SNN_START, COPROCESSOR_RDY, BUSY, OVERRUN, TIMEOUT_ERR;
  logic [23:0]        INFER_CYCLES;

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;

  snn_inference_ctrl #(
    .IMAGE_SIZE(N), .IMAGE_SIZE_BITS(8), .PIXEL_BITS(8), .DIGIT_BITS(8), .CYCLE_CNT_BITS(24)
`ifdef SNN_INFER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .NEW_IMAGE(NEW_IMAGE), .IMAGE(IMAGE),
    .PIX_DATA(PIX_DATA), .PIX_ADDR(PIX_ADDR), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .SNN_START(SNN_START), .SNN_DONE(SNN_DONE), .SNN_DIGIT(SNN_DIGIT),
    .INFERED_DIGIT(INFERED_DIGIT), .COPROCESSOR_RDY(COPROCESSOR_RDY), .RESULT_ACK(RESULT_ACK),
    .BUSY(BUSY), .OVERRUN(OVERRUN), .INFER_CYCLES(INFER_CYCLES), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Core-side ready pattern: 0 always ready, 1 alternating, 2 random.
  initial begin
    PIX_READY = 1'b1;
    forever begin
      tick();
      case (ready_mode)
        0:       PIX_READY = 1'b1;
        1:       PIX_READY = ~PIX_READY;
        default: PIX_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  int    load_cyc = 0, beats = 0, n_start = 0, last_load_len = 0;
  logic  first_ready = 1'b0;
  logic  prev_start = 1'b0, prev_rdy = 1'b0, prev_last = 1'b0, last_now;
  beat_t eb;
  res_t  er;

  initial begin
    forever begin
      @(negedge CLK);
      last_now = 1'b0;
      if (RST) begin
        load_cyc   = 0;
        beats      = 0;
        prev_start = 1'b0;
        prev_rdy   = 1'b0;
        prev_last  = 1'b0;
      end else begin
        if (PIX_VALID) begin
          if (load_cyc == 0) first_ready = PIX_READY;
          load_cyc++;
          if (pix_q.size() == 0) begin
            check("pix_unexpected", 1, 0);
          end else begin
            eb = pix_q[0];
            check("pix_addr", PIX_ADDR, eb.addr);
            check("pix_data", PIX_DATA, eb.data);
            if (PIX_READY) begin
              last_now = (eb.addr == 8'(N - 1));
              void'(pix_q.pop_front());
              beats++;
            end
          end
        end
        if (SNN_START) begin
          check("start_beats", beats, N);
          check("start_after_last", prev_last, 1);
          check("start_single", prev_start, 0);
          last_load_len = load_cyc;
          n_start++;
          load_cyc = 0;
          beats    = 0;
        end
        if (COPROCESSOR_RDY && !prev_rdy) begin
          if (res_q.size() == 0) begin
            check("rdy_unexpected", 1, 0);
          end else begin
            er = res_q.pop_front();
            check("res_digit", INFERED_DIGIT, er.digit);
            if (er.cycles >= 0) check("res_cycles", INFER_CYCLES, er.cycles);
            check("res_timeout", TIMEOUT_ERR, er.tmo);
          end
        end
        prev_start = SNN_START;
        prev_rdy   = COPROCESSOR_RDY;
        prev_last  = last_now;
      end
    end
  end

  task automatic fill_image(input bit ramp);
    beat_t b;
    for (int i = 0; i < N; i++) begin
      IMAGE[i] = ramp ? 8'(i) : 8'($urandom);
      b.addr = 8'(i);
      b.data = IMAGE[i];
      pix_q.push_back(b);
    end
  endtask

  task automatic start_image(input bit ramp, input bit chk_cycles, input bit with_ack);
    fill_image(ramp);
    NEW_IMAGE = 1'b0;
    tick();
    NEW_IMAGE  = 1'b1;
    RESULT_ACK = with_ack;
    tick();
    RESULT_ACK = 1'b0;
    check("load_busy", BUSY, 1);
    check("load_valid", PIX_VALID, 1);
    check("load_rdy_low", COPROCESSOR_RDY, 0);
    if (chk_cycles) check("load_cycles_clr", INFER_CYCLES, 0);
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (COPROCESSOR_RDY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("rdy_wait_expired", 0, 1);
  endtask

  // Reference: a DONE d cycles after START reports d+1 cycles, unless the watchdog fires first.
  task automatic infer(input int d, input logic [7:0] dg, input bit send_done);
    res_t r;
    bit   ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (SNN_START) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("start_wait_expired", 0, 1);
      return;
    end
    r.tmo    = TMO_EN && (d >= TMO);
    r.digit  = r.tmo ? 8'hFF : dg;
    r.cycles = r.tmo ? -1 : d + 1;
    res_q.push_back(r);
    SNN_DIGIT = dg;
    if (send_done) begin
      if (d == 0) SNN_DONE = 1'b1;
      else begin
        repeat (d) @(posedge CLK);
        #1;
        SNN_DONE = 1'b1;
      end
      tick();
      SNN_DONE = 1'b0;
    end
    wait_rdy(ok);
  endtask

  task automatic do_ack();
    tick();
    RESULT_ACK = 1'b1;
    tick();
    RESULT_ACK = 1'b0;
    check("ack_rdy", COPROCESSOR_RDY, 0);
    check("ack_busy", BUSY, 0);
  endtask

  int  starts_before;
  bit  found;

  initial begin
    RST = 1'b1; NEW_IMAGE = 1'b0; SNN_DONE = 1'b0; RESULT_ACK = 1'b0; SNN_DIGIT = '0; IMAGE = '0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    check("rst_valid", PIX_VALID, 0);
    check("rst_addr", PIX_ADDR, 0);
    check("rst_data", PIX_DATA, 0);
    check("rst_start", SNN_START, 0);
    check("rst_rdy", COPROCESSOR_RDY, 0);
    check("rst_digit", INFERED_DIGIT, 0);
    check("rst_busy", BUSY, 0);
    check("rst_overrun", OVERRUN, 0);
    check("rst_cycles", INFER_CYCLES, 0);
    check("rst_timeout", TIMEOUT_ERR, 0);

    // Ramp image, always ready, DONE 40 cycles after START with digit 3.
    ready_mode = 0;
    start_image(1'b1, 1'b1, 1'b0);
    infer(40, 8'd3, 1'b1);
    check("ramp_load_len", last_load_len, N);
    check("digit3", INFERED_DIGIT, 3);
    check("cycles41", INFER_CYCLES, 41);
    check("rdy_held", COPROCESSOR_RDY, 1);
    check("result_not_busy", BUSY, 0);
    do_ack();

    // DONE while idle is ignored.
    SNN_DONE = 1'b1;
    tick();
    SNN_DONE = 1'b0;
    tick();
    check("idle_done_ignored", COPROCESSOR_RDY, 0);

    // Alternating ready: each address holds until accepted.
    ready_mode = 1;
    start_image(1'b0, 1'b1, 1'b0);
    infer(0, 8'($urandom), 1'b1);
    check("toggle_load_len", last_load_len, first_ready ? 2 * N - 1 : 2 * N);
    do_ack();

    // ACK and edge in the same cycle: reload without OVERRUN.
    ready_mode = 2;
    start_image(1'b0, 1'b1, 1'b0);
    infer(7, 8'($urandom), 1'b1);
    start_image(1'b0, 1'b0, 1'b1);
    check("ack_edge_no_overrun", OVERRUN, 0);
    infer(3, 8'($urandom), 1'b1);
    do_ack();

    for (int k = 0; k < 5; k++) begin
      ready_mode = int'($urandom_range(0, 2));
      start_image(1'b0, 1'b1, 1'b0);
      infer(int'($urandom_range(0, 60)), 8'($urandom), 1'b1);
      do_ack();
    end

    // Edge during LOAD (plus a stray DONE) leaves the stream untouched and sets OVERRUN.
    ready_mode = 0;
    start_image(1'b0, 1'b1, 1'b0);
    repeat (30) tick();
    NEW_IMAGE = 1'b0;
    tick();
    NEW_IMAGE = 1'b1;
    SNN_DONE  = 1'b1;
    tick();
    SNN_DONE = 1'b0;
    check("load_edge_overrun", OVERRUN, 1);
    check("load_edge_busy", BUSY, 1);
    infer(12, 8'($urandom), 1'b1);

    // Edge while the result is unread discards it and reloads.
    start_image(1'b0, 1'b0, 1'b0);
    check("result_edge_overrun", OVERRUN, 1);
    infer(20, 8'($urandom), 1'b1);
    do_ack();

`ifdef SNN_INFER_TIMEOUT_EN
    start_image(1'b0, 1'b1, 1'b0);
    infer(1000, 8'h5A, 1'b0);
    check("wd_err", TIMEOUT_ERR, 1);
    check("wd_digit", INFERED_DIGIT, 8'hFF);
    do_ack();
    start_image(1'b0, 1'b1, 1'b0);
    check("wd_err_cleared", TIMEOUT_ERR, 0);
    infer(TMO - 1, 8'h21, 1'b1);
    do_ack();
`endif

    // Reset in the middle of the stream.
    start_image(1'b0, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (PIX_VALID && PIX_ADDR == 8'd100) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("beat100_wait_expired", 0, 1);
    RST = 1'b1;
    NEW_IMAGE = 1'b0;
    pix_q.delete();
    @(negedge CLK);
    check("mid_rst_valid", PIX_VALID, 0);
    check("mid_rst_addr", PIX_ADDR, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_overrun", OVERRUN, 0);
    check("mid_rst_digit", INFERED_DIGIT, 0);
    check("mid_rst_cycles", INFER_CYCLES, 0);
    starts_before = n_start;
    tick();
    RST = 1'b0;
    repeat (20) tick();
    check("no_start_after_rst", n_start, starts_before);
    check("idle_after_rst", BUSY, 0);

    // NEW_IMAGE already high when reset releases counts as an edge.
    RST = 1'b1;
    NEW_IMAGE = 1'b1;
    tick();
    fill_image(1'b1);
    tick();
    RST = 1'b0;
    tick();
    check("rst_high_edge_busy", BUSY, 1);
    infer(2, 8'd9, 1'b1);
    do_ack();
    check("queues_drained", pix_q.size() + res_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
